// File: rtl/clb_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clb_cfg_pkg
// Shared definitions for the CLB mux-slice configuration loader:
//   - default slice count / config width, shared with the slice instantiation
//   - FSM state encoding (localparams plus the enum built from them)
//   - target-counter width helper
// No ports (package).
// -----------------------------------------------------------------------------
package clb_cfg_pkg;

  localparam int CFG_NUM_TARGETS  = 4;
  localparam int CFG_TARGET_WIDTH = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_CHECK  = ST_CHECK,
    S_COMMIT = ST_COMMIT,
    S_FINISH = ST_FINISH
  } state_t;

  // A single target still needs a 1-bit counter.
  function automatic int tgt_cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfg_deser.sv
// -----------------------------------------------------------------------------
// cfg_deser
// Shadow shift register and bit counter for one configuration word.
// Bits land LSB first at shadow[bitcnt]. With CLB_CFG_PARITY_EN defined the
// shadow is one bit wider and holds the trailing even-parity bit.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_clear       return the bit counter to 0 (start of a new word)
//   i_shift       accept i_bit this cycle
//   i_bit         serial data bit
//   o_word_nxt    word including the bit being accepted now (no-parity build)
//   o_word        registered word bits (parity build)
//   o_parity_ok   XOR over word and parity bit is 0 (parity build)
//   o_last        the bit counter points at the final bit of the word
//
// Build option: CLB_CFG_PARITY_EN
// -----------------------------------------------------------------------------
module cfg_deser
  import clb_cfg_pkg::*;
#(
  parameter int TARGET_WIDTH = CFG_TARGET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_shift,
  input  logic                    i_bit,
`ifdef CLB_CFG_PARITY_EN
  output logic [TARGET_WIDTH-1:0] o_word,
  output logic                    o_parity_ok,
`else
  output logic [TARGET_WIDTH-1:0] o_word_nxt,
`endif
  output logic                    o_last
);

`ifdef CLB_CFG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int SW   = TARGET_WIDTH + PAR_BITS;
  localparam int BC_W = $clog2(TARGET_WIDTH + 1);

  logic [SW-1:0]   r_shadow;
  logic [BC_W-1:0] r_bitcnt;

  assign o_last = (r_bitcnt == BC_W'(SW - 1));

  // The counter stops on the last bit; the next word starts with i_clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_bitcnt <= '0;
    end else if (i_clear) begin
      r_bitcnt <= '0;
    end else if (i_shift) begin
      r_shadow[r_bitcnt] <= i_bit;
      if (!o_last) r_bitcnt <= r_bitcnt + BC_W'(1);
    end
  end

`ifdef CLB_CFG_PARITY_EN
  assign o_word      = r_shadow[TARGET_WIDTH-1:0];
  assign o_parity_ok = ~(^r_shadow);
`else
  // Without a CHECK cycle the commit happens straight off the last bit, so
  // the word is taken with that bit already merged in.
  logic [SW-1:0] w_shadow_nxt;
  always_comb begin
    w_shadow_nxt           = r_shadow;
    w_shadow_nxt[r_bitcnt] = i_bit;
  end
  assign o_word_nxt = w_shadow_nxt[TARGET_WIDTH-1:0];
`endif

endmodule

// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
// Serial configuration sequencer for the CLB mux slices. Deserializes one
// TARGET_WIDTH-bit word per slice (LSB first), drives it on the shared
// config_out bus and strobes the matching comb_set bit for one cycle.
// Slices are loaded in order 0 .. NUM_TARGETS-1.
//
// Handshake: cfg_bit is consumed on a rising edge where cfg_valid && cfg_ready.
// cfg_ready is a registered output that depends only on the FSM state (high
// throughout SHIFT); cfg_valid low simply stalls, with no timeout.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a sequence (sampled only in IDLE)
//   cfg_bit     serial config data, LSB first
//   cfg_valid   cfg_bit valid
//   cfg_ready   loader accepts a bit this cycle
//   config_out  shared config word, held until the next commit
//   comb_set    one-hot commit strobe, bit i to slice i
//   busy        not in IDLE
//   done        one-cycle pulse at sequence end
//   err         sticky parity error (tied 0 without CLB_CFG_PARITY_EN)
//   dbg_state   current FSM state (clb_cfg_pkg ST_* encoding)
//
// Build option: CLB_CFG_PARITY_EN adds a trailing even-parity bit per word and
// a CHECK state; a failing word ends the sequence with err set.
// -----------------------------------------------------------------------------
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_TARGETS  = CFG_NUM_TARGETS,
  parameter int TARGET_WIDTH = CFG_TARGET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_bit,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [TARGET_WIDTH-1:0] config_out,
  output logic [NUM_TARGETS-1:0]  comb_set,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              dbg_state
);

  localparam int               TGT_W    = tgt_cnt_width(NUM_TARGETS);
  localparam logic [TGT_W-1:0] TGT_LAST = TGT_W'(NUM_TARGETS - 1);

  state_t                  r_state;
  logic [TGT_W-1:0]        r_tgt;
  logic                    r_cfg_ready;
  logic [TARGET_WIDTH-1:0] r_config_out;
  logic [NUM_TARGETS-1:0]  r_comb_set;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_shift;
  logic                    w_clear;
  logic                    w_last;
  logic [NUM_TARGETS-1:0]  w_onehot;
`ifdef CLB_CFG_PARITY_EN
  logic                    r_err;
  logic [TARGET_WIDTH-1:0] w_word;
  logic                    w_parity_ok;
`else
  logic [TARGET_WIDTH-1:0] w_word_nxt;
`endif

  assign w_shift  = r_cfg_ready & cfg_valid;
  // Bit counter restarts while idle and during each commit, so every SHIFT
  // phase begins at bit 0.
  assign w_clear  = (r_state == S_IDLE) || (r_state == S_COMMIT);
  assign w_onehot = NUM_TARGETS'(1) << r_tgt;

  cfg_deser #(
    .TARGET_WIDTH (TARGET_WIDTH)
  ) u_deser (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_shift     (w_shift),
    .i_bit       (cfg_bit),
`ifdef CLB_CFG_PARITY_EN
    .o_word      (w_word),
    .o_parity_ok (w_parity_ok),
`else
    .o_word_nxt  (w_word_nxt),
`endif
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tgt        <= '0;
      r_cfg_ready  <= 1'b0;
      r_config_out <= '0;
      r_comb_set   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
      r_err        <= 1'b0;
`endif
    end else begin
      // Strobes last exactly one cycle unless re-asserted below.
      r_comb_set <= '0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tgt <= '0;
          if (start) begin
            r_state     <= S_SHIFT;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
`ifdef CLB_CFG_PARITY_EN
            r_err       <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (w_shift && w_last) begin
            r_cfg_ready <= 1'b0;
`ifdef CLB_CFG_PARITY_EN
            r_state     <= S_CHECK;
`else
            r_state      <= S_COMMIT;
            r_config_out <= w_word_nxt;
            r_comb_set   <= w_onehot;
`endif
          end
        end
`ifdef CLB_CFG_PARITY_EN
        S_CHECK: begin
          if (w_parity_ok) begin
            r_state      <= S_COMMIT;
            r_config_out <= w_word;
            r_comb_set   <= w_onehot;
          end else begin
            // Bad word: skip the commit and end the sequence flagged.
            r_err   <= 1'b1;
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end
        end
`endif
        S_COMMIT: begin
          if (r_tgt == TGT_LAST) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_tgt       <= r_tgt + TGT_W'(1);
            r_state     <= S_SHIFT;
            r_cfg_ready <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign config_out = r_config_out;
  assign comb_set   = r_comb_set;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;
`ifdef CLB_CFG_PARITY_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_clb_cfg_loader
// Bench for clb_cfg_loader: a 4x3 instance for the main sequences and a 1x1
// instance for the smallest configuration. Expected commit/done cycles are
// derived from the sequencing rules (bits per word, check cycle, commit cycle,
// stall length) and queued before each load.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clb_cfg_loader;
  import clb_cfg_pkg::*;

  localparam int N = 4;
  localparam int W = 3;
`ifdef CLB_CFG_PARITY_EN
  localparam int SB = W + 1;   // bits shifted per word
  localparam int XC = 1;       // check cycles per word
  localparam int SB_B = 2;
`else
  localparam int SB = W;
  localparam int XC = 0;
  localparam int SB_B = 1;
`endif
  localparam int P     = SB + XC + 1;  // cycles per target
  localparam int EXP_W = 32 + N + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (4 x 3) ----------------
  logic         start, cfg_bit, cfg_valid;
  logic         cfg_ready, busy, done, err;
  logic [W-1:0] config_out;
  logic [N-1:0] comb_set;
  logic [2:0]   dbg_state;

  clb_cfg_loader #(.NUM_TARGETS(N), .TARGET_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_bit(cfg_bit), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .config_out(config_out), .comb_set(comb_set),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- DUT B (1 x 1) ----------------
  logic       b_start, b_bit, b_valid;
  logic       b_ready, b_busy, b_done, b_err;
  logic [0:0] b_cfg, b_set;
  logic [2:0] b_dbg;

  clb_cfg_loader #(.NUM_TARGETS(1), .TARGET_WIDTH(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .cfg_bit(b_bit), .cfg_valid(b_valid),
    .cfg_ready(b_ready), .config_out(b_cfg), .comb_set(b_set),
    .busy(b_busy), .done(b_done), .err(b_err), .dbg_state(b_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];   // {cycle, one-hot, word}
  logic [32:0]      done_q[$];  // {cycle, err}
  logic [EXP_W-1:0] mon_e;
  logic [32:0]      mon_d;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (comb_set !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_comb_set", 64'(comb_set), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("set_cycle",  64'(cyc),        64'(mon_e[EXP_W-1 -: 32]));
          check("set_onehot", 64'(comb_set),   64'(mon_e[N+W-1 -: N]));
          check("set_word",   64'(config_out), 64'(mon_e[W-1:0]));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_d[32:1]));
          check("done_err",   64'(err), 64'(mon_d[0]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic [W-1:0] words [N];
  logic [W-1:0] last_word;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    guard     = 0;
    cfg_bit   = b;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    check("ready_wait", 64'(cfg_ready), 64'(1));
    step();
  endtask

  task automatic stall(input int len, input bit poke);
    cfg_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      cfg_bit = 1'($urandom_range(0, 1));
      start   = poke;
      step();
    end
    start = 1'b0;
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // One full sequence. stall_word < 0 means no stall, bad_word < 0 means all
  // parity bits correct. poke pulses start during the stall and in FINISH.
  task automatic run_load(input int stall_word, input int stall_bit, input int stall_len,
                          input int bad_word, input bit poke);
    int           t0, base, extra, done_cyc, last_k;
    logic [W-1:0] wk;
    logic         pbit;
    t0       = cyc;
    extra    = 0;
    done_cyc = 0;
    last_k   = (bad_word >= 0) ? bad_word : N - 1;
    for (int k = 0; k <= last_k; k++) begin
      if (k == stall_word) extra += stall_len;
      base = t0 + 1 + k * P + extra;
      if (k == bad_word) done_cyc = base + SB + XC;
      else exp_q.push_back({32'(base + SB + XC), onehot(k), words[k]});
    end
    if (bad_word < 0) begin
      done_cyc  = t0 + 1 + N * P + extra;
      last_word = words[N-1];
    end else if (bad_word > 0) begin
      last_word = words[bad_word-1];
    end
    done_q.push_back({32'(done_cyc), (bad_word >= 0)});

    start     = 1'b1;
    cfg_valid = 1'b0;
    step();
    start = 1'b0;
    check("busy_c1",  64'(busy),      64'(1));
    check("ready_c1", 64'(cfg_ready), 64'(1));
    check("err_c1",   64'(err),       64'(0));

    for (int k = 0; k <= last_k; k++) begin
      wk = words[k];
      for (int b = 0; b < SB; b++) begin
        if (k == stall_word && b == stall_bit) stall(stall_len, poke);
        if (b < W) pbit = wk[b];
        else       pbit = (^wk) ^ (k == bad_word);
        send_bit(pbit);
      end
    end
    cfg_valid = 1'b0;
    while (cyc < done_cyc) step();
    start = poke;   // lands in the FINISH cycle
    step();
    start = 1'b0;
    repeat (4) step();
    check("idle_busy",  64'(busy),       64'(0));
    check("idle_ready", 64'(cfg_ready),  64'(0));
    check("idle_state", 64'(dbg_state),  64'(ST_IDLE));
    check("cfg_hold",   64'(config_out), 64'(last_word));
    check("err_after",  64'(err),        64'(bad_word >= 0));
    check("sb_empty",   64'(exp_q.size()),  64'(0));
    check("done_empty", 64'(done_q.size()), 64'(0));
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},  64'(cfg_ready),  64'(0));
    check({tag, "_cfg"},    64'(config_out), 64'(0));
    check({tag, "_set"},    64'(comb_set),   64'(0));
    check({tag, "_busy"},   64'(busy),       64'(0));
    check({tag, "_done"},   64'(done),       64'(0));
    check({tag, "_err"},    64'(err),        64'(0));
    check({tag, "_state"},  64'(dbg_state),  64'(ST_IDLE));
  endtask

  // Reset while shifting the third word; the first two commits must occur.
  task automatic reset_mid();
    int           t0;
    logic [W-1:0] wk;
    t0 = cyc;
    for (int k = 0; k < 2; k++) exp_q.push_back({32'(t0 + 1 + k * P + SB + XC), onehot(k), words[k]});
    start     = 1'b1;
    cfg_valid = 1'b0;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wk = words[k];
      for (int b = 0; b < SB; b++) send_bit((b < W) ? wk[b] : ^wk);
    end
    wk = words[2];
    send_bit(wk[0]);
    rst = 1'b1;
    step();
    check_reset_values("rst_mid");
    check("rst_mid_sb", 64'(exp_q.size()), 64'(0));
    rst       = 1'b0;
    cfg_valid = 1'b0;
    last_word = '0;
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) words[k] = W'($urandom_range(0, (1 << W) - 1));
  endtask

  // Smallest configuration: expectations per relative cycle from the rules.
  task automatic boundary_1x1();
    int t0, c, commit_c, done_c;
    commit_c = SB_B + XC + 1;
    done_c   = commit_c + 1;
    b_start = 1'b1;
    b_valid = 1'b1;
    b_bit   = 1'b1;
    t0 = cyc;
    step();
    b_start = 1'b0;
    c = cyc - t0;
    while (c <= done_c + 1) begin
      check("b_ready", 64'(b_ready), 64'(c >= 1 && c <= SB_B));
      check("b_set",   64'(b_set),   64'(c == commit_c));
      check("b_done",  64'(b_done),  64'(c == done_c));
      check("b_busy",  64'(b_busy),  64'(c >= 1 && c <= done_c));
      if (c >= commit_c) check("b_cfg", 64'(b_cfg), 64'(1));
      step();
      c = cyc - t0;
    end
    b_valid = 1'b0;
    check("b_err", 64'(b_err), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sw, sbit, slen;
    bit poke;
    rst = 1'b1; start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    b_start = 1'b0; b_bit = 1'b0; b_valid = 1'b0;
    last_word = '0;
    repeat (3) step();
    check_reset_values("reset");
    check("reset_b_set", 64'(b_set), 64'(0));
    rst = 1'b0;
    step();

    // Nominal: commits at 4/8/12/16, done at 17 (no parity build).
    words[0] = 3'b101; words[1] = 3'b010; words[2] = 3'b111; words[3] = 3'b001;
    run_load(-1, 0, 0, -1, 1'b0);

    // Backpressure of 5 cycles mid-word, start poked in SHIFT and FINISH.
    run_load(1, 1, 5, -1, 1'b1);

    fill_random();
    reset_mid();
    words[0] = 3'b011; words[1] = 3'b100; words[2] = 3'b110; words[3] = 3'b000;
    run_load(-1, 0, 0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      fill_random();
      sw   = int'($urandom_range(0, N));
      if (sw == N) sw = -1;
      sbit = int'($urandom_range(1, SB - 1));
      slen = int'($urandom_range(1, 6));
      poke = 1'($urandom_range(0, 1));
      run_load(sw, sbit, slen, -1, poke);
    end

`ifdef CLB_CFG_PARITY_EN
    words[0] = 3'b101; words[1] = 3'b110; words[2] = 3'b001; words[3] = 3'b111;
    run_load(-1, 0, 0, -1, 1'b0);
    run_load(-1, 0, 0, 0, 1'b0);    // 101 with parity 1: no commit, err
    run_load(-1, 0, 0, -1, 1'b0);   // err cleared by the new start
    fill_random();
    run_load(-1, 0, 0, int'($urandom_range(1, N - 1)), 1'b1);
`endif

    boundary_1x1();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
